// File: rtl/serial_frame_tx_if.sv
// Word handshake into serial_frame_tx.
// Producer drives data_in/data_valid; transmitter drives data_ready.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start marker, payload bits, low gap.
// Define SERIAL_FRAME_TX_PARITY_EN to append an even-parity bit.
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2,
  parameter int MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  serial_frame_tx_if.slave bus,
  output logic             ser_out,
  output logic             busy,
  output logic             frame_done,
  output logic [1:0]       state
);

  localparam int CW = $clog2(DATA_W + 2);
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int N = DATA_W + 1;
`else
  localparam int N = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    SHIFT = 2'b10,
    GAP   = 2'b11
  } st_t;

  st_t               st;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nx;
  logic [CW-1:0]     cnt;
  logic [3:0]        gcnt;
  logic              dbit;
  logic              nxt;

  assign bus.data_ready = (st == IDLE);
  assign state          = st;

  always_comb begin
    dbit  = 1'b0;
    sh_nx = sh;
    if (MSB_FIRST != 0) begin
      dbit  = sh[DATA_W-1];
      sh_nx = sh << 1;
    end else begin
      dbit  = sh[0];
      sh_nx = sh >> 1;
    end
  end

`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic par;

  // Parity is latched with the word, so it follows the data in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= 1'b0;
    end else if (st == IDLE && bus.data_valid) begin
      par <= ^bus.data_in;
    end
  end

  assign nxt = (cnt == CW'(DATA_W)) ? par : dbit;
`else
  assign nxt = dbit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      sh         <= '0;
      cnt        <= '0;
      gcnt       <= '0;
      ser_out    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.data_valid) begin
            sh      <= bus.data_in;
            cnt     <= '0;
            gcnt    <= '0;
            st      <= START;
            ser_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        START: begin
          st      <= SHIFT;
          ser_out <= dbit;
          sh      <= sh_nx;
          cnt     <= CW'(1);
        end
        SHIFT: begin
          // cnt counts bits already put on the line
          if (cnt == CW'(N)) begin
            ser_out <= 1'b0;
            if (GAP_CYCLES > 0) begin
              st   <= GAP;
              gcnt <= 4'd1;
            end else begin
              st         <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end else begin
            ser_out <= nxt;
            sh      <= sh_nx;
            cnt     <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == 4'(GAP_CYCLES)) begin
            st         <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx (two instances: MSB/gap2, LSB/gap0).
// Expected streams are hand-written for both parity builds.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.DATA_W(8)) if0 ();
  serial_frame_tx_if #(.DATA_W(8)) if1 ();

  logic       s0, b0, d0;
  logic       s1, b1, d1;
  logic [1:0] st0, st1;

  serial_frame_tx #(
    .DATA_W(8), .GAP_CYCLES(2), .MSB_FIRST(1)
  ) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave),
    .ser_out(s0), .busy(b0),
    .frame_done(d0), .state(st0)
  );

  serial_frame_tx #(
    .DATA_W(8), .GAP_CYCLES(0), .MSB_FIRST(0)
  ) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave),
    .ser_out(s1), .busy(b1),
    .frame_done(d1), .state(st1)
  );

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int L = 12;
  localparam logic [15:0] E_A5 =
    16'({1'b1, 8'hA5, 1'b0, 2'b00});
  localparam logic [15:0] E_07 =
    16'({1'b1, 8'h07, 1'b1, 2'b00});
  localparam logic [15:0] E_81 =
    16'({1'b1, 8'h81, 1'b0, 2'b00});
  localparam int L1 = 10;
  localparam logic [15:0] E_01 =
    16'({1'b1, 8'b1000_0000, 1'b1});
  localparam logic [31:0] E_BB =
    32'({1'b1, 8'h3C, 1'b0, 2'b00, 1'b0,
         1'b1, 8'hC3, 1'b0, 2'b00});
`else
  localparam int L = 11;
  localparam logic [15:0] E_A5 =
    16'({1'b1, 8'hA5, 2'b00});
  localparam logic [15:0] E_07 =
    16'({1'b1, 8'h07, 2'b00});
  localparam logic [15:0] E_81 =
    16'({1'b1, 8'h81, 2'b00});
  localparam int L1 = 9;
  localparam logic [15:0] E_01 =
    16'({1'b1, 8'b1000_0000});
  localparam logic [31:0] E_BB =
    32'({1'b1, 8'h3C, 2'b00, 1'b0,
         1'b1, 8'hC3, 2'b00});
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input int          w,
    input logic [7:0]  d,
    input logic [15:0] exp,
    input int          len,
    input string       tag
  );
    if (w == 0) begin
      if0.data_in    = d;
      if0.data_valid = 1'b1;
    end else begin
      if1.data_in    = d;
      if1.data_valid = 1'b1;
    end
    step();
    if0.data_valid = 1'b0;
    if1.data_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s_ser%0d", tag, i),
          32'(w != 0 ? s1 : s0), 32'(exp[len-1-i]));
      chk($sformatf("%s_busy%0d", tag, i),
          32'(w != 0 ? b1 : b0), 32'd1);
      chk($sformatf("%s_rdy%0d", tag, i),
          32'(w != 0 ? if1.data_ready : if0.data_ready),
          32'd0);
      step();
    end
    chk({tag, "_end_rdy"},
        32'(w != 0 ? if1.data_ready : if0.data_ready),
        32'd1);
    chk({tag, "_end_done"},
        32'(w != 0 ? d1 : d0), 32'd1);
    chk({tag, "_end_busy"},
        32'(w != 0 ? b1 : b0), 32'd0);
    chk({tag, "_end_ser"},
        32'(w != 0 ? s1 : s0), 32'd0);
    step();
    chk({tag, "_done_clr"},
        32'(w != 0 ? d1 : d0), 32'd0);
  endtask

  int bcnt;
  int dcnt;

  initial begin
    rst            = 1'b1;
    if0.data_in    = '0;
    if0.data_valid = 1'b0;
    if1.data_in    = '0;
    if1.data_valid = 1'b0;

    #10;
    chk("rst_ser", 32'(s0), 32'd0);
    chk("rst_state", 32'(st0), 32'd0);
    chk("rst_rdy", 32'(if0.data_ready), 32'd1);
    chk("rst_busy", 32'(b0), 32'd0);
    chk("rst_done", 32'(d0), 32'd0);
    #2 rst = 1'b0;
    step();
    chk("rel_ser", 32'(s0), 32'd0);
    chk("rel_state", 32'(st0), 32'd0);
    chk("rel_rdy", 32'(if0.data_ready), 32'd1);
    chk("rel_busy", 32'(b0), 32'd0);
    chk("rel_done", 32'(d0), 32'd0);

    send(0, 8'hA5, E_A5, L, "a5");
    send(0, 8'h07, E_07, L, "p07");
    send(1, 8'h01, E_01, L1, "lsb01");

    // back-to-back with ignored data_in changes
    if0.data_in    = 8'h3C;
    if0.data_valid = 1'b1;
    step();
    bcnt = 0;
    dcnt = 0;
    for (int c = 1; c <= 2*L + 4; c++) begin
      if (c <= 2*L + 1)
        chk($sformatf("b2b_ser%0d", c), 32'(s0),
            32'(E_BB[2*L+1-c]));
      if (c == L + 1)
        chk("b2b_rdy", 32'(if0.data_ready), 32'd1);
      if (c == L + 2)
        chk("b2b_start", 32'(st0), 32'd1);
      bcnt += int'(b0);
      dcnt += int'(d0);
      if (c == 4) if0.data_in = 8'hFF;
      if (c == 8) if0.data_in = 8'hC3;
      if (c == L + 2) if0.data_valid = 1'b0;
      step();
    end
    chk("b2b_busy_cycles", 32'(bcnt), 32'(2*L));
    chk("b2b_done_pulses", 32'(dcnt), 32'd2);

    // reset during the 4th data bit of 8'hF0
    if0.data_in    = 8'hF0;
    if0.data_valid = 1'b1;
    step();
    if0.data_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_bit4", 32'(s0), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_ser", 32'(s0), 32'd0);
    chk("mid_state", 32'(st0), 32'd0);
    chk("mid_done", 32'(d0), 32'd0);
    chk("mid_busy", 32'(b0), 32'd0);
    chk("mid_rdy", 32'(if0.data_ready), 32'd1);
    #1 rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      dcnt += int'(d0);
    end
    chk("mid_no_done", 32'(dcnt), 32'd0);
    chk("mid_idle", 32'(st0), 32'd0);

    send(0, 8'h81, E_81, L, "x81");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Generates the framed serial bit stream that `simple_fsm`-style sequence detectors consume on their 1-bit `in` input.
- Accepts a parallel word over a valid/ready handshake.
- Emits a 1-cycle start marker, then the data bits one per clock, then a low inter-frame gap.
- Drives the detector under test in benches and on-chip pattern links; exposes its 2-bit state for waveform debug.

Parameters:
- DATA_W, 8: payload width in bits; legal range 1..32.
- GAP_CYCLES, 2: low cycles inserted after each frame; legal range 0..15.
- MSB_FIRST, 1: 1 = shift out data_in[DATA_W-1] first; 0 = shift out data_in[0] first.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_W  payload word; sampled only on the accept edge.
- data_valid  input  1  producer has a word available.
- data_ready  output  1  block can accept a word; combinational, equals (state == IDLE).
- ser_out  output  1  registered serial line; idle level 0.
- busy  output  1  registered; 1 whenever state != IDLE.
- frame_done  output  1  registered 1-cycle pulse when a frame, including its gap, completes.
- state  output  2  current FSM state.

Behaviour:
- Clock and reset:
  - One clock domain (`clk`). Reset is asynchronous and active-high (`rst`).
  - On reset assertion, immediately: state=IDLE, ser_out=0, busy=0, frame_done=0, shift register=0, bit counter=0. This makes data_ready=1.
- State encoding: IDLE=2'b00, START=2'b01, SHIFT=2'b10, GAP=2'b11.
- Accept:
  - Occurs on a rising edge with data_valid=1 and data_ready=1.
  - On that edge: load the shift register from data_in, set the bit counter to 0, state->START, ser_out<=1, busy<=1.
- START (exactly 1 cycle, ser_out=1): next edge state->SHIFT, ser_out<=first data bit.
- SHIFT:
  - One bit per edge, in MSB_FIRST order.
  - ser_out holds each data bit for exactly one cycle. N = DATA_W, or DATA_W+1 with the optional feature.
  - After the last bit has been held for one cycle:
    - GAP_CYCLES>0: state->GAP, ser_out<=0.
    - GAP_CYCLES=0: state->IDLE, ser_out<=0, frame_done<=1.
- GAP: ser_out=0 for exactly GAP_CYCLES cycles, then state->IDLE and frame_done<=1 for one cycle.
- Timing:
  - Frame length, accept edge to data_ready high: 1 + N + GAP_CYCLES cycles.
  - Back-to-back: if data_valid is high when data_ready returns, the next word is accepted on that same cycle's edge. The next START follows immediately, with no extra idle cycle.
- Ignored inputs:
  - data_valid and data_in are ignored while busy; no buffering, no overwrite of the word in flight.
  - data_in changes outside the accept edge have no effect.
- Reset mid-frame: the frame is discarded, all outputs return to reset values immediately, and no frame_done pulse is produced.
- Bit counter width: $clog2(DATA_W+2). The gap counter is 4 bits. Neither counter may wrap within a legal frame.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of all DATA_W payload bits) is appended after the last data bit, still in SHIFT. N=DATA_W+1.
  - The parity is computed from the word latched at accept.
- Undefined: no parity bit, N=DATA_W, no parity logic synthesized.
- State encoding and all other timing are identical in both builds.

Test Plan:
- Reset: hold rst=1 for 10 ns, data_valid=0 -> ser_out=0, state=2'b00, data_ready=1, busy=0, frame_done=0. Release; outputs remain unchanged.
- Single frame, defaults, data_in=8'hA5, 1-cycle valid pulse:
  - ser_out per cycle = 1,1,0,1,0,0,1,0,1,0,0.
  - data_ready=1 and frame_done=1 on cycle 12. busy high cycles 1..11.
- Bit order, MSB_FIRST=0, data_in=8'h01, GAP_CYCLES=0: ser_out = 1,1,0,0,0,0,0,0,0 then idle. frame_done coincides with the first idle cycle.
- Back-to-back with ignored data:
  - Hold data_valid=1 with 8'h3C; change data_in to 8'hFF mid-frame, then 8'hC3 before the frame ends.
  - Expect frame 1 = 8'h3C (8'hFF ignored), frame 2 = 8'hC3 accepted the cycle data_ready rises.
  - Exactly 2 frame_done pulses, 22 cycles total.
- Reset mid-frame: assert rst during the 4th data bit -> same delta ser_out=0, state=2'b00, no frame_done. The next frame, 8'h81, is transmitted correctly.
- Parity build (SERIAL_FRAME_TX_PARITY_EN defined):
  - 8'hA5 -> parity bit 0 after the data bits.
  - 8'h07 -> parity bit 1.
  - Frame length 12 cycles with GAP_CYCLES=2.
